// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC coefficient transmitter.
// Frame geometry matches the DCT stage output.
package mfcc_pkg;

    localparam int NUM_CEPS   = 12;
    localparam int CEPS_WIDTH = 17;

    typedef logic [CEPS_WIDTH-1:0] ceps_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } coef_tx_state_e;

endpackage

// File: rtl/coef_pingpong_bank.sv
// Two-bank coefficient store with per-frame write mask and per-bank full flags.
// Commit and release are resolved together so a bank freed this cycle can be refilled.
module coef_pingpong_bank #(
    parameter int NUM_CEPS   = 12,
    parameter int CEPS_WIDTH = 17,
    parameter int PTR_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [PTR_W-1:0]      wr_ptr_i,
    input  logic [CEPS_WIDTH-1:0] wr_data_i,
    input  logic                  commit_i,
    input  logic                  rel_en_i,
    input  logic                  rel_bank_i,
    input  logic                  rd_bank_i,
    input  logic [PTR_W-1:0]      rd_idx_i,
    output logic [CEPS_WIDTH-1:0] rd_data_o,
    output logic [1:0]            full_d_o,
    output logic                  wr_bank_d_o,
    output logic                  commit_drop_o
);

    logic [CEPS_WIDTH-1:0] mem_q [2][NUM_CEPS];
    logic [NUM_CEPS-1:0]   mask_q, mask_d;
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  wr_bank_free;
    logic                  wr_store;

    // A full capture bank is write-protected until the reader releases it, so a
    // third frame arriving while both banks hold data is lost (drop-newest).
    always_comb begin
        wr_bank_free  = !full_q[wr_bank_q] || (rel_en_i && (rel_bank_i == wr_bank_q));
        wr_store      = wr_en_i && (int'(wr_ptr_i) < NUM_CEPS) && wr_bank_free;
        mask_d        = mask_q;
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        commit_drop_o = 1'b0;
        if (rel_en_i) begin
            full_d[rel_bank_i] = 1'b0;
        end
        if (wr_store) begin
            mask_d[wr_ptr_i] = 1'b1;
        end
        if (commit_i) begin
            if ((&mask_d) && wr_bank_free) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                commit_drop_o = 1'b1;
            end
            mask_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q    <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem_q[wr_bank_q][wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o   = mem_q[rd_bank_i][rd_idx_i];
    assign full_d_o    = full_d;
    assign wr_bank_d_o = wr_bank_d;

endmodule

// File: rtl/mfcc_coef_tx.sv
// Captures DCT cepstral frames into a ping-pong store and streams them on valid/ready.
// Build option MFCC_COEF_TX_STATS_EN enables the frame/drop statistics counters.
module mfcc_coef_tx #(
    parameter int NUM_CEPS   = mfcc_pkg::NUM_CEPS,
    parameter int CEPS_WIDTH = mfcc_pkg::CEPS_WIDTH,
    parameter int PTR_W      = $clog2(NUM_CEPS),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dct_valid_i,
    input  logic [PTR_W-1:0]      ceps_ptr_i,
    input  logic [CEPS_WIDTH-1:0] ceps_sample_i,
    input  logic                  dct_done_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [CEPS_WIDTH-1:0] m_data_o,
    output logic                  m_first_o,
    output logic                  m_last_o,
    output logic                  drop_o,
    output logic [CNT_W-1:0]      frame_cnt_o,
    output logic [CNT_W-1:0]      drop_cnt_o
);

    import mfcc_pkg::coef_tx_state_e;
    import mfcc_pkg::IDLE;
    import mfcc_pkg::STREAM;

    coef_tx_state_e        state_q, state_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]      idx_q, idx_d;
    logic                  drop_q;
    logic [CEPS_WIDTH-1:0] rd_data;
    logic [1:0]            full_d;
    logic                  wr_bank_d;
    logic                  commit_drop;
    logic                  fire;
    logic                  last_beat;
    logic                  oldest_bank;

    assign fire      = (state_q == STREAM) && m_ready_i;
    assign last_beat = fire && (idx_q == PTR_W'(NUM_CEPS - 1));

    coef_pingpong_bank #(
        .NUM_CEPS   (NUM_CEPS),
        .CEPS_WIDTH (CEPS_WIDTH),
        .PTR_W      (PTR_W)
    ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (dct_valid_i),
        .wr_ptr_i      (ceps_ptr_i),
        .wr_data_i     (ceps_sample_i),
        .commit_i      (dct_done_i),
        .rel_en_i      (last_beat),
        .rel_bank_i    (rd_bank_q),
        .rd_bank_i     (rd_bank_q),
        .rd_idx_i      (idx_q),
        .rd_data_o     (rd_data),
        .full_d_o      (full_d),
        .wr_bank_d_o   (wr_bank_d),
        .commit_drop_o (commit_drop)
    );

    // When both banks are full the older one is the next capture target, since
    // the write bank toggled away from it on the later commit.
    assign oldest_bank = full_d[wr_bank_d] ? wr_bank_d : ~wr_bank_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
            drop_q    <= commit_drop;
        end
    end

    // Looking at next-cycle full flags gives one-cycle commit-to-valid latency
    // and back-to-back frames without a bubble.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (|full_d) begin
                    state_d   = STREAM;
                    rd_bank_d = oldest_bank;
                    idx_d     = '0;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    idx_d = '0;
                    if (|full_d) begin
                        rd_bank_d = oldest_bank;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fire) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_valid_o = (state_q == STREAM);
        m_data_o  = m_valid_o ? rd_data : '0;
        m_first_o = m_valid_o && (idx_q == '0);
        m_last_o  = m_valid_o && (idx_q == PTR_W'(NUM_CEPS - 1));
        drop_o    = drop_q;
    end

`ifdef MFCC_COEF_TX_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + CNT_W'(last_beat);
        drop_cnt_d  = drop_cnt_q + CNT_W'(commit_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign drop_cnt_o  = '0;
`endif

endmodule
